// File: rtl/mult_issue.sv
// Operand issue / result capture stage around a 4x4 shift-add multiplier.
// Holds operands, pulses start, waits for a fresh done (or timeout), and hands off the product.
module mult_issue #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             mult_start,
  output logic [3:0]       mult_dataa,
  output logic [3:0]       mult_datab,
  input  logic             mult_done,
  input  logic [7:0]       mult_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_product,
  output logic             res_error,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_mult_start;
  logic [3:0]       r_dataa;
  logic [3:0]       r_datab;
  logic             r_res_valid;
  logic [7:0]       r_res_product;
  logic             r_res_error;
  logic [CNT_W-1:0] r_op_count;
  logic             r_busy;
  logic [TW-1:0]    r_tcnt;

  logic [3:0]       w_dataa_nxt;
  logic [3:0]       w_datab_nxt;
  logic [7:0]       w_prod_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [TW-1:0]    w_tcnt_nxt;
  logic [TW-1:0]    w_tcnt_inc;
  logic             w_in_ready_nxt;
  logic             w_start_nxt;
  logic             w_res_valid_nxt;
  logic             w_busy_nxt;

  // Next-state and next-output logic; a done sampled on the timeout cycle still wins.
  always_comb begin
    w_state_nxt = r_state;
    w_dataa_nxt = r_dataa;
    w_datab_nxt = r_datab;
    w_prod_nxt  = r_res_product;
    w_err_nxt   = r_res_error;
    w_cnt_nxt   = r_op_count;
    w_tcnt_nxt  = r_tcnt;
    w_tcnt_inc  = r_tcnt + TW'(1);

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_dataa_nxt = in_a;
          w_datab_nxt = in_b;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        w_tcnt_nxt  = '0;
        w_state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        w_tcnt_nxt = w_tcnt_inc;
        if (w_tcnt_inc == TMO) begin
          w_prod_nxt  = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = RESULT;
        end else if (!mult_done) begin
          w_state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        w_tcnt_nxt = w_tcnt_inc;
        if (mult_done) begin
          w_prod_nxt  = mult_product;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = r_op_count + CNT_W'(1);
          w_state_nxt = RESULT;
        end else if (w_tcnt_inc == TMO) begin
          w_prod_nxt  = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt == IDLE);
    w_busy_nxt      = (w_state_nxt != IDLE);
    w_start_nxt     = (w_state_nxt == LAUNCH);
    w_res_valid_nxt = (w_state_nxt == RESULT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_in_ready    <= 1'b1;
      r_mult_start  <= 1'b0;
      r_dataa       <= '0;
      r_datab       <= '0;
      r_res_valid   <= 1'b0;
      r_res_product <= '0;
      r_res_error   <= 1'b0;
      r_op_count    <= '0;
      r_busy        <= 1'b0;
      r_tcnt        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_mult_start  <= w_start_nxt;
      r_dataa       <= w_dataa_nxt;
      r_datab       <= w_datab_nxt;
      r_res_valid   <= w_res_valid_nxt;
      r_res_product <= w_prod_nxt;
      r_res_error   <= w_err_nxt;
      r_op_count    <= w_cnt_nxt;
      r_busy        <= w_busy_nxt;
      r_tcnt        <= w_tcnt_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign mult_start  = r_mult_start;
  assign mult_dataa  = r_dataa;
  assign mult_datab  = r_datab;
  assign res_valid   = r_res_valid;
  assign res_product = r_res_product;
  assign res_error   = r_res_error;
  assign op_count    = r_op_count;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mult_issue.sv
// Directed scoreboard bench for mult_issue with a behavioural multiplier model.
module tb_mult_issue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic       mult_start;
  logic [3:0] mult_dataa;
  logic [3:0] mult_datab;
  logic       mult_done = 1'b0;
  logic [7:0] mult_product = 8'h00;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_product;
  logic       res_error;
  logic [7:0] op_count;
  logic       busy;

  mult_issue #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_start(mult_start), .mult_dataa(mult_dataa), .mult_datab(mult_datab),
    .mult_done(mult_done), .mult_product(mult_product),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .res_error(res_error), .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: done stays at its old level for mdl_lo_dly edges after the start edge,
  // then low, then high with the product 4 edges later (never, when mdl_hang is set).
  int mdl_lo_dly = 0;
  bit mdl_hang = 1'b0;
  bit m_act = 1'b0;
  int m_e = 0;

  always @(posedge clk) begin
    if (mult_start) begin
      m_act        <= 1'b1;
      m_e          <= 1;
      mult_product <= 8'hA5;
      if (mdl_lo_dly == 0) mult_done <= 1'b0;
    end else if (m_act) begin
      m_e <= m_e + 1;
      if (m_e == mdl_lo_dly) mult_done <= 1'b0;
      if (!mdl_hang && m_e == mdl_lo_dly + 4) begin
        mult_done    <= 1'b1;
        mult_product <= 8'(mult_dataa) * 8'(mult_datab);
        m_act        <= 1'b0;
      end
    end
  end

  int         vec = 0;
  int         errs = 0;
  int         starts = 0;
  logic [8:0] sb_q[$];
  logic [7:0] exp_cnt = 8'd0;
  logic [3:0] exp_a = 4'd0;
  logic [3:0] exp_b = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vec++;
    assert (obs === req) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // One clock: inspect the current cycle (handshake fires on the coming edge), then advance.
  task automatic tick();
    logic [8:0] e;
    if (mult_start) starts++;
    if (busy) begin
      chk("hold_a", 32'(mult_dataa), 32'(exp_a));
      chk("hold_b", 32'(mult_datab), 32'(exp_b));
    end
    if (res_valid && res_ready) begin
      vec++;
      assert (sb_q.size() > 0) else begin
        errs++;
        $error("FAIL unexpected_result observed=%0h expected=none", res_product);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (!e[8]) exp_cnt = exp_cnt + 8'd1;
        chk("res_product", 32'(res_product), 32'(e[7:0]));
        chk("res_error", 32'(res_error), 32'(e[8]));
        chk("op_count", 32'(op_count), 32'(exp_cnt));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input bit err);
    int w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    exp_a = a;
    exp_b = b;
    sb_q.push_back(err ? 9'h100 : {1'b0, 8'(a) * 8'(b)});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || sb_q.size() != 0) && w < 200) begin
      tick();
      w++;
    end
    chk("idle_budget", 32'(w < 200), 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_start", 32'(mult_start), 32'd0);
    chk("rst_dataa", 32'(mult_dataa), 32'd0);
    chk("rst_datab", 32'(mult_datab), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_product", 32'(res_product), 32'd0);
    chk("rst_res_error", 32'(res_error), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int s0;
    logic [3:0] ra;
    logic [3:0] rb;

    // Reset state
    tick();
    tick();
    chk_reset();
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();

    // Single op 7x9; accept edge N -> res_valid after edge N+6
    issue(4'd7, 4'd9, 1'b0);
    wait_valid(lat);
    chk("lat_best", 32'(lat), 32'd6);
    wait_idle();
    chk("starts_single", 32'(starts), 32'd1);
    chk("count_single", 32'(op_count), 32'd1);

    // Back-to-back with done left high across the start; stale done must be discarded
    mdl_lo_dly = 3;
    issue(4'd15, 4'd15, 1'b0);
    issue(4'd0, 4'd5, 1'b0);
    wait_idle();
    chk("starts_b2b", 32'(starts), 32'd3);
    chk("count_b2b", 32'(op_count), 32'd3);

    // Backpressure: result holds, no new accept
    mdl_lo_dly = 0;
    res_ready = 1'b0;
    issue(4'd3, 4'd4, 1'b0);
    wait_valid(lat);
    in_valid = 1'b1;
    in_a = 4'd9;
    in_b = 4'd9;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_product", 32'(res_product), 32'h0C);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    s0 = starts;
    res_ready = 1'b1;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_single_result", 32'(res_valid), 32'd0);
    end
    chk("bp_starts", 32'(starts), 32'(s0));

    // Timeout: LAUNCH ends at edge N+1, counter hits 15 at edge N+16
    mdl_hang = 1'b1;
    issue(4'd5, 4'd5, 1'b1);
    wait_valid(lat);
    chk("lat_timeout", 32'(lat), 32'd16);
    chk("to_product", 32'(res_product), 32'd0);
    chk("to_error", 32'(res_error), 32'd1);
    wait_idle();
    chk("to_count", 32'(op_count), 32'd4);
    mdl_hang = 1'b0;
    issue(4'd2, 4'd3, 1'b0);
    wait_idle();

    // Done sampled on the very timeout edge counts as success; one edge later is a timeout
    mdl_lo_dly = 10;
    issue(4'd4, 4'd5, 1'b0);
    wait_valid(lat);
    chk("lat_edge_ok", 32'(lat), 32'd16);
    wait_idle();
    mdl_lo_dly = 11;
    issue(4'd4, 4'd5, 1'b1);
    wait_idle();
    chk("count_edges", 32'(op_count), 32'd6);

    // Asynchronous reset in WAIT_HI
    mdl_lo_dly = 0;
    issue(4'd6, 4'd7, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    void'(sb_q.pop_back());
    exp_cnt = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_no_result", 32'(res_valid), 32'd0);
    end
    chk("post_rst_busy", 32'(busy), 32'd0);
    issue(4'd1, 4'd1, 1'b0);
    wait_idle();

    // op_count wrap after 256 successful ops
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      issue(ra, rb, 1'b0);
      wait_idle();
    end
    chk("count_wrap", 32'(op_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
